// File: rtl/snd_cmd_latch.sv
// snd_cmd_latch: sound-board end of the main-CPU -> sound-CPU command path.
// Captures the command byte on each rising edge of the write strobe, tracks
// pending/overrun status, and drives a stretched, re-armable active-low NMI.
module snd_cmd_latch #(
  parameter int NMI_CE_CYCLES   = 32,
  parameter int REARM_CE_CYCLES = 2
) (
  input  logic       clk_49m,
  input  logic       reset_n,
  input  logic       pause,
  input  logic       cpu_ce,
  input  logic [7:0] sound_cmd,
  input  logic       sound_cmd_wr,
  input  logic       snd_rd,
  output logic [7:0] latch_q,
  output logic       nmi_n,
  output logic       cmd_pending,
  output logic [7:0] overrun_cnt
);

  localparam int CNT_MAX = (NMI_CE_CYCLES > REARM_CE_CYCLES) ? NMI_CE_CYCLES : REARM_CE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_NMI   = CW'(NMI_CE_CYCLES);
  localparam logic [CW-1:0] CNT_REARM = CW'(REARM_CE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_REARM
  } nmi_state_t;

  nmi_state_t    state;
  logic [CW-1:0] cnt;
  logic          wr_d;
  logic          wr_rise;
  logic          ce_cnt;

  assign wr_rise = sound_cmd_wr & ~wr_d;
  assign ce_cnt  = cpu_ce & ~pause;

  // Write-strobe edge detector; resets high so a strobe held through reset is ignored.
  always_ff @(posedge clk_49m) begin
    if (!reset_n) wr_d <= 1'b1;
    else          wr_d <= sound_cmd_wr;
  end

  // Command capture plus pending/overrun bookkeeping; a write beats a same-cycle read.
  always_ff @(posedge clk_49m) begin
    if (!reset_n) begin
      latch_q     <= '0;
      cmd_pending <= 1'b0;
      overrun_cnt <= '0;
    end else if (wr_rise) begin
      latch_q     <= sound_cmd;
      cmd_pending <= 1'b1;
      if (cmd_pending && !snd_rd && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + 8'd1;
    end else if (snd_rd) begin
      cmd_pending <= 1'b0;
    end
  end

  // NMI sequencer: one shared down-counter times both the low pulse and the re-arm gap.
  always_ff @(posedge clk_49m) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      nmi_n <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_rise) begin
            state <= S_ASSERT;
            cnt   <= CNT_NMI;
            nmi_n <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (wr_rise) begin
            state <= S_REARM;
            cnt   <= CNT_REARM;
            nmi_n <= 1'b1;
          end else if (ce_cnt) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state <= S_IDLE;
              nmi_n <= 1'b1;
            end
          end
        end
        S_REARM: begin
          // Writes here only touch the latch/flags; the gap keeps running.
          if (ce_cnt) begin
            if (cnt == CNT_ONE) begin
              state <= S_ASSERT;
              cnt   <= CNT_NMI;
              nmi_n <= 1'b0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          nmi_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
